// File: rtl/kbd_pkg.sv
// Shared scancode constants, btnstate bit positions, state encodings and
// small helpers for the PS/2 arrow-key decoder.
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_BASE   = 2'd0,
    DEC_EXT    = 2'd1,
    DEC_EXTBRK = 2'd2,
    DEC_BRK    = 2'd3
  } dec_state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return (^{data, par}) == 1'b1;
  endfunction

  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] mask;
    mask = 4'b0000;
    case (code)
      SC_UP:    mask[BTN_UP]    = 1'b1;
      SC_DOWN:  mask[BTN_DOWN]  = 1'b1;
      SC_LEFT:  mask[BTN_LEFT]  = 1'b1;
      SC_RIGHT: mask[BTN_RIGHT] = 1'b1;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, 11-bit
// frame FSM with odd-parity/stop checking and an inter-edge timeout.
module ps2_rx_frame
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_r, data_sync_r;
  logic          filt_level_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s, data_bit_s;

  rx_state_t     state_r, state_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shift_r, shift_s;
  logic          par_r, par_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic          byte_valid_r, valid_s;
  logic [7:0]    byte_data_r, data_s;
  logic          frame_err_r, err_s;

  // Falling edge: the filter is about to flip from 1 to 0 this cycle.
  assign fall_s     = filt_level_r & ~clk_sync_r[1] & (filt_cnt_r == FILT_LAST);
  assign data_bit_s = data_sync_r[1];

  // Synchronisers and the ps2_clk level filter (idle-high after reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r   <= 2'b11;
      data_sync_r  <= 2'b11;
      filt_level_r <= 1'b1;
      filt_cnt_r   <= {FW{1'b0}};
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      if (clk_sync_r[1] == filt_level_r) begin
        filt_cnt_r <= {FW{1'b0}};
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_level_r <= clk_sync_r[1];
        filt_cnt_r   <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  // Frame FSM next state; an edge always wins over a same-cycle timeout.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    par_s     = par_r;
    valid_s   = 1'b0;
    err_s     = 1'b0;
    data_s    = byte_data_r;
    if (state_r == RX_IDLE || fall_s) begin
      to_cnt_s = {TW{1'b0}};
    end else begin
      to_cnt_s = to_cnt_r + TW'(1);
    end
    if (fall_s) begin
      case (state_r)
        RX_IDLE: begin
          if (!data_bit_s) begin
            state_s   = RX_DATA;
            bit_cnt_s = 3'd0;
          end else begin
            state_s = RX_IDLE;
          end
        end
        RX_DATA: begin
          shift_s = {data_bit_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_s = RX_PARITY;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
        RX_PARITY: begin
          par_s   = data_bit_s;
          state_s = RX_STOP;
        end
        RX_STOP: begin
          state_s = RX_IDLE;
          if (data_bit_s && odd_parity_ok(shift_r, par_r)) begin
            valid_s = 1'b1;
            data_s  = shift_r;
          end else begin
            err_s = 1'b1;
          end
        end
        default: state_s = RX_IDLE;
      endcase
    end else if (state_r != RX_IDLE && to_cnt_r == TO_LAST) begin
      state_s = RX_IDLE;
      shift_s = 8'h00;
      err_s   = 1'b1;
    end else begin
      state_s = state_r;
    end
  end

  // Frame FSM registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RX_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      to_cnt_r     <= {TW{1'b0}};
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      shift_r      <= shift_s;
      par_r        <= par_s;
      to_cnt_r     <= to_cnt_s;
      byte_valid_r <= valid_s;
      byte_data_r  <= data_s;
      frame_err_r  <= err_s;
    end
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow-key decoder: turns extended make/break scancode sequences into
// a held-key vector (up, down, left, right).
module ps2_arrow_decoder
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] btnstate,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic       byte_valid_s;
  logic [7:0] byte_data_s;
  logic       frame_err_s;
  dec_state_t dec_r, dec_s;
  logic [3:0] btn_r, btn_s, mask_s;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .frame_err  (frame_err_s)
  );

  assign mask_s = arrow_mask(byte_data_s);

  // Scancode decoder; frame errors never reach here, so they leave state alone.
  always_comb begin
    dec_s = dec_r;
    btn_s = btn_r;
    if (byte_valid_s) begin
      case (dec_r)
        DEC_BASE: begin
          if (byte_data_s == SC_EXT) begin
            dec_s = DEC_EXT;
          end else if (byte_data_s == SC_BRK) begin
            dec_s = DEC_BRK;
          end else begin
            dec_s = DEC_BASE;
          end
        end
        DEC_EXT: begin
          if (byte_data_s == SC_BRK) begin
            dec_s = DEC_EXTBRK;
          end else if (byte_data_s == SC_EXT) begin
            dec_s = DEC_EXT;
          end else begin
            btn_s = btn_r | mask_s;
            dec_s = DEC_BASE;
          end
        end
        DEC_EXTBRK: begin
          btn_s = btn_r & ~mask_s;
          dec_s = DEC_BASE;
        end
        DEC_BRK: dec_s = DEC_BASE;
        default: dec_s = DEC_BASE;
      endcase
    end else begin
      dec_s = dec_r;
    end
  end

  // Decoder state and held-key register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_r <= DEC_BASE;
      btn_r <= 4'b0000;
    end else begin
      dec_r <= dec_s;
      btn_r <= btn_s;
    end
  end

  assign btnstate   = btn_r;
  assign byte_valid = byte_valid_s;
  assign byte_data  = byte_data_s;
  assign frame_err  = frame_err_s;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Self-checking bench for ps2_arrow_decoder: directed scenarios plus random
// key traffic against a scancode-stream reference model.
module tb_ps2_arrow_decoder;

  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] btnstate;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  ps2_arrow_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .btnstate   (btnstate),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc = 0, n_bv = 0, n_err = 0, exp_bv = 0, exp_err = 0;
  int last_bv_cyc = 0, last_btn_cyc = 0, fall_cyc = 0;
  logic [3:0] btn_prev = 4'b0000;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  // Reference model: held keys plus the pending prefix bytes (E0 / E0 F0 / F0).
  logic [3:0] m_btn = 4'b0000;
  logic [7:0] pend[$];

  function automatic logic [3:0] key_bit(input logic [7:0] c);
    case (c)
      8'h75:   return 4'b1000;
      8'h72:   return 4'b0100;
      8'h6B:   return 4'b0010;
      8'h74:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
    end else if (pend[0] == 8'hF0) begin
      pend.delete();
    end else if (pend.size() == 2) begin
      m_btn = m_btn & ~key_bit(b);
      pend.delete();
    end else if (b == 8'hF0) begin
      pend.push_back(b);
    end else if (b != 8'hE0) begin
      m_btn = m_btn | key_bit(b);
      pend.delete();
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (byte_valid === 1'b1) begin
      n_bv++;
      rx_q.push_back(byte_data);
      last_bv_cyc = cyc;
    end
    if (frame_err === 1'b1) n_err++;
    if (btnstate !== btn_prev) begin
      last_btn_cyc = cyc;
      btn_prev = btnstate;
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (3 * H) @(negedge clk);
    if (bad_par || bad_stop) begin
      exp_err++;
    end else begin
      exp_bv++;
      exp_q.push_back(b);
      model_byte(b);
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    total++; if (btnstate !== 4'b0000) $display("FAIL reset_btn: got %b want 0000", btnstate); else passed++;
    total++; if (byte_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", byte_valid); else passed++;
    total++; if (byte_data !== 8'h00) $display("FAIL reset_data: got %h want 00", byte_data); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_err); else passed++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_up_make;
    send_good(8'hE0);
    send_good(8'h75);
    total++; if (n_bv !== 2) $display("FAIL up_valid_count: got %0d want 2", n_bv); else passed++;
    total++; if (btnstate !== 4'b1000) $display("FAIL up_btn: got %b want 1000", btnstate); else passed++;
    total++; if (last_btn_cyc - last_bv_cyc !== 1) $display("FAIL up_btn_latency: got %0d want 1", last_btn_cyc - last_bv_cyc); else passed++;
    total++;
    if (last_bv_cyc - fall_cyc < 8 || last_bv_cyc - fall_cyc > 13)
      $display("FAIL up_valid_latency: got %0d want 8..13", last_bv_cyc - fall_cyc);
    else passed++;
    total++; if (byte_data !== 8'h75) $display("FAIL up_byte_data: got %h want 75", byte_data); else passed++;
  endtask

  task automatic test_combo;
    send_good(8'hE0); send_good(8'h6B);
    total++; if (btnstate !== 4'b1010) $display("FAIL combo_left: got %b want 1010", btnstate); else passed++;
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    total++; if (btnstate !== 4'b0010) $display("FAIL combo_up_break: got %b want 0010", btnstate); else passed++;
    send_good(8'hE0); send_good(8'h6B);
    total++; if (btnstate !== 4'b0010) $display("FAIL typematic: got %b want 0010", btnstate); else passed++;
    send_good(8'hE0); send_good(8'hF0); send_good(8'h72);
    total++; if (btnstate !== 4'b0010) $display("FAIL break_unheld: got %b want 0010", btnstate); else passed++;
    send_good(8'hE0); send_good(8'hF0); send_good(8'h6B);
    total++; if (btnstate !== 4'b0000) $display("FAIL combo_clear: got %b want 0000", btnstate); else passed++;
  endtask

  task automatic test_nonext;
    send_good(8'h1D); send_good(8'hF0); send_good(8'h1D);
    total++; if (btnstate !== 4'b0000) $display("FAIL nonext_btn: got %b want 0000", btnstate); else passed++;
    send_good(8'h75);
    total++; if (btnstate !== 4'b0000) $display("FAIL nonext_base: got %b want 0000", btnstate); else passed++;
    send_good(8'hE0); send_good(8'hE0); send_good(8'h72);
    total++; if (btnstate !== 4'b0100) $display("FAIL double_e0: got %b want 0100", btnstate); else passed++;
    send_good(8'hE0); send_good(8'hF0); send_good(8'h72);
  endtask

  task automatic test_parity_err;
    int e0;
    e0 = n_err;
    send_good(8'hE0);
    send_frame(8'h72, 1'b1, 1'b0);
    total++; if (n_err - e0 !== 1) $display("FAIL parity_err_count: got %0d want 1", n_err - e0); else passed++;
    total++; if (btnstate !== 4'b0000) $display("FAIL parity_err_btn: got %b want 0000", btnstate); else passed++;
    send_good(8'h72);
    total++; if (btnstate !== 4'b0100) $display("FAIL parity_recover: got %b want 0100", btnstate); else passed++;
    send_frame(8'hE0, 1'b0, 1'b1);
    total++; if (n_err - e0 !== 2) $display("FAIL stop_err_count: got %0d want 2", n_err - e0); else passed++;
    send_good(8'h74);
    total++; if (btnstate !== 4'b0100) $display("FAIL stop_err_base: got %b want 0100", btnstate); else passed++;
  endtask

  task automatic test_timeout;
    int e0, v0;
    e0 = n_err;
    v0 = n_bv;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    repeat (TO - 100 - H) @(negedge clk);
    total++; if (n_err !== e0) $display("FAIL timeout_early: got %0d errs want 0", n_err - e0); else passed++;
    repeat (200) @(negedge clk);
    total++; if (n_err - e0 !== 1) $display("FAIL timeout_err: got %0d want 1", n_err - e0); else passed++;
    repeat (300) @(negedge clk);
    exp_err++;
    total++; if (n_bv !== v0) $display("FAIL timeout_novalid: got %0d want %0d", n_bv, v0); else passed++;
    send_good(8'hE0); send_good(8'h74);
    total++; if (btnstate !== 4'b0101) $display("FAIL timeout_recover: got %b want 0101", btnstate); else passed++;
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = n_bv;
    e0 = n_err;
    for (int g = 0; g < 12; g++) begin
      ps2_data = 1'($urandom_range(0, 1));
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (30) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (TO + 100) @(negedge clk);
    total++; if (n_bv !== v0) $display("FAIL glitch_valid: got %0d want %0d", n_bv, v0); else passed++;
    total++; if (n_err !== e0) $display("FAIL glitch_err: got %0d want %0d", n_err, e0); else passed++;
    total++; if (btnstate !== 4'b0101) $display("FAIL glitch_btn: got %b want 0101", btnstate); else passed++;
  endtask

  task automatic test_random;
    logic [7:0] arrows [4];
    logic [7:0] b;
    int bad;
    arrows[0] = 8'h75; arrows[1] = 8'h72; arrows[2] = 8'h6B; arrows[3] = 8'h74;
    for (int ev = 0; ev < 25; ev++) begin
      case ($urandom_range(0, 4))
        0: begin send_good(8'hE0); send_good(arrows[$urandom_range(0, 3)]); end
        1: begin send_good(8'hE0); send_good(8'hF0); send_good(arrows[$urandom_range(0, 3)]); end
        2: begin b = 8'($urandom_range(0, 255)); send_good(b); end
        3: begin
          b = 8'($urandom_range(0, 255));
          bad = $urandom_range(0, 1);
          send_frame(b, 1'(bad), 1'(1 - bad));
        end
        default: begin send_good(8'hE0); b = 8'($urandom_range(0, 255)); send_good(b); end
      endcase
      total++; if (btnstate !== m_btn) $display("FAIL rand_btn_%0d: got %b want %b", ev, btnstate, m_btn); else passed++;
    end
    total++; if (n_bv !== exp_bv) $display("FAIL rand_valid_count: got %0d want %0d", n_bv, exp_bv); else passed++;
    total++; if (n_err !== exp_err) $display("FAIL rand_err_count: got %0d want %0d", n_err, exp_err); else passed++;
    total++; if (rx_q.size() !== exp_q.size()) $display("FAIL rand_byte_count: got %0d want %0d", rx_q.size(), exp_q.size()); else passed++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] got, want;
      got = rx_q.pop_front();
      want = exp_q.pop_front();
      total++; if (got !== want) $display("FAIL rand_byte: got %h want %h", got, want); else passed++;
    end
  endtask

  task automatic test_reset_midframe;
    send_good(8'hE0); send_good(8'h75);
    send_good(8'hE0); send_good(8'h72);
    send_good(8'hE0); send_good(8'h6B);
    send_good(8'hE0); send_good(8'h74);
    total++; if (btnstate !== 4'b1111) $display("FAIL all_held: got %b want 1111", btnstate); else passed++;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (btnstate !== 4'b0000) $display("FAIL midrst_btn: got %b want 0000", btnstate); else passed++;
    total++; if (byte_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", byte_data); else passed++;
    total++; if (byte_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL midrst_pulses: got %b%b want 00", byte_valid, frame_err); else passed++;
    m_btn = 4'b0000;
    pend.delete();
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_good(8'hE0); send_good(8'h74);
    total++; if (btnstate !== 4'b0001) $display("FAIL midrst_recover: got %b want 0001", btnstate); else passed++;
    total++; if (btnstate !== m_btn) $display("FAIL midrst_model: got %b want %b", btnstate, m_btn); else passed++;
  endtask

  initial begin
    test_reset();
    test_up_make();
    test_combo();
    test_nonext();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
